// File: rtl/qspi_flash_arbiter.sv
// Two-requester arbiter for the shared configuration QSPI flash pads.
// Grants exclusive ownership, muxes the owner's pad controls, and enforces a guard gap and a watchdog.
module qspi_flash_arbiter #(
  parameter int GUARD_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  output logic       gnt0,
  input  logic       ss0_o,
  input  logic       ss0_t,
  input  logic [3:0] io0_o,
  input  logic [3:0] io0_t,
  output logic [3:0] io0_i,
  input  logic       req1,
  output logic       gnt1,
  input  logic       ss1_o,
  input  logic       ss1_t,
  input  logic [3:0] io1_o,
  input  logic [3:0] io1_t,
  output logic [3:0] io1_i,
  output logic       ss_o,
  output logic       ss_t,
  output logic [3:0] io_o,
  output logic [3:0] io_t,
  input  logic [3:0] io_i,
  output logic [1:0] owner,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GUARD = 2'd2} state_t;

  localparam logic [7:0]       GUARD_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WD_EN      = (TIMEOUT_CYCLES != 0);

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             lockout0_q, lockout0_d;
  logic             lockout1_q, lockout1_d;
  logic [7:0]       guard_q, guard_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             timeout_q, timeout_d;

  logic elig0, elig1, own_req, other_elig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 2'b00;
      last_owner_q <= 1'b1;
      lockout0_q   <= 1'b0;
      lockout1_q   <= 1'b0;
      guard_q      <= '0;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lockout0_q   <= lockout0_d;
      lockout1_q   <= lockout1_d;
      guard_q      <= guard_d;
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
    end
  end

  assign elig0      = req0 & ~lockout0_q;
  assign elig1      = req1 & ~lockout1_q;
  assign own_req    = owner_q[0] ? req0  : req1;
  assign other_elig = owner_q[0] ? elig1 : elig0;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    guard_d      = guard_q;
    wdog_d       = wdog_q;
    timeout_d    = 1'b0;
    // A lockout survives only while its request stays high.
    lockout0_d   = lockout0_q & req0;
    lockout1_d   = lockout1_q & req1;

    case (state_q)
      IDLE: begin
        if (elig0 && (!elig1 || last_owner_q)) begin
          state_d      = OWN;
          owner_d      = 2'b01;
          last_owner_d = 1'b0;
          wdog_d       = '0;
        end else if (elig1) begin
          state_d      = OWN;
          owner_d      = 2'b10;
          last_owner_d = 1'b1;
          wdog_d       = '0;
        end
      end
      OWN: begin
        // A release on the expiry edge wins over the revoke.
        if (!own_req) begin
          state_d = GUARD;
          owner_d = 2'b00;
          guard_d = GUARD_LAST;
        end else if (WD_EN && other_elig && (wdog_q == WD_LAST)) begin
          state_d   = GUARD;
          owner_d   = 2'b00;
          guard_d   = GUARD_LAST;
          timeout_d = 1'b1;
          if (owner_q[0]) lockout0_d = 1'b1;
          else            lockout1_d = 1'b1;
        end else if (other_elig) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      GUARD: begin
        if (guard_q == 8'd0) state_d = IDLE;
        else                 guard_d = guard_q - 8'd1;
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'b00;
      end
    endcase
  end

  // Pad mux follows the registered owner so the idle value appears in the cycle owner clears.
  always_comb begin
    gnt0    = (owner_q == 2'b01);
    gnt1    = (owner_q == 2'b10);
    owner   = owner_q;
    timeout = timeout_q;
    ss_o    = 1'b1;
    ss_t    = 1'b0;
    io_o    = 4'h0;
    io_t    = 4'hF;
    io0_i   = 4'h0;
    io1_i   = 4'h0;
    case (owner_q)
      2'b01: begin
        ss_o  = ss0_o;
        ss_t  = ss0_t;
        io_o  = io0_o;
        io_t  = io0_t;
        io0_i = io_i;
      end
      2'b10: begin
        ss_o  = ss1_o;
        ss_t  = ss1_t;
        io_o  = io1_o;
        io_t  = io1_t;
        io1_i = io_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// Directed testbench for qspi_flash_arbiter: grant latency, guard gap, fairness,
// watchdog revoke with lockout, release/expiry collision and mid-ownership reset.
module tb_qspi_flash_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic       ss0_o, ss0_t, ss1_o, ss1_t;
  logic [3:0] io0_o, io0_t, io1_o, io1_t;
  logic [3:0] io0_i, io1_i;
  logic       ss_o, ss_t;
  logic [3:0] io_o, io_t, io_i;
  logic [1:0] owner;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int who;

  always #5 clk = ~clk;

  qspi_flash_arbiter #(
    .GUARD_CYCLES  (8),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (17)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .gnt0   (gnt0),
    .ss0_o  (ss0_o),
    .ss0_t  (ss0_t),
    .io0_o  (io0_o),
    .io0_t  (io0_t),
    .io0_i  (io0_i),
    .req1   (req1),
    .gnt1   (gnt1),
    .ss1_o  (ss1_o),
    .ss1_t  (ss1_t),
    .io1_o  (io1_o),
    .io1_t  (io1_t),
    .io1_i  (io1_i),
    .ss_o   (ss_o),
    .ss_t   (ss_t),
    .io_o   (io_o),
    .io_t   (io_t),
    .io_i   (io_i),
    .owner  (owner),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, output int w);
    int n = 0;
    w = -1;
    while (!gnt0 && !gnt1 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(gnt0 | gnt1), 32'd1);
    if (gnt0)      w = 0;
    else if (gnt1) w = 1;
  endtask

  task automatic check_idle_bus(input string tag);
    chk({tag, "_ss_o"}, 32'(ss_o), 32'd1);
    chk({tag, "_ss_t"}, 32'(ss_t), 32'd0);
    chk({tag, "_io_t"}, 32'(io_t), 32'hF);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    ss0_o = 1'b0; ss0_t = 1'b0; io0_o = 4'h5; io0_t = 4'h0;
    ss1_o = 1'b0; ss1_t = 1'b1; io1_o = 4'hC; io1_t = 4'h3;
    io_i  = 4'hA;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state and idle bus value
    $display("phase: reset state");
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_io_o", 32'(io_o), 0);
    chk("rst_io0_i", 32'(io0_i), 0);
    check_idle_bus("rst");

    // Single request: one-cycle latency, mux follows requester 0
    $display("phase: single request");
    repeat (3) tick();
    req0 = 1'b1;
    chk("t1_pre_gnt0", 32'(gnt0), 0);
    tick();
    chk("t1_gnt0", 32'(gnt0), 1);
    chk("t1_owner", 32'(owner), 32'h1);
    chk("t1_ss_o", 32'(ss_o), 0);
    chk("t1_ss_t", 32'(ss_t), 0);
    chk("t1_io_o", 32'(io_o), 32'h5);
    chk("t1_io_t", 32'(io_t), 32'h0);
    chk("t1_io0_i", 32'(io0_i), 32'hA);
    chk("t1_io1_i", 32'(io1_i), 32'h0);
    req0 = 1'b0;
    tick();
    chk("t1_rel_gnt0", 32'(gnt0), 0);
    repeat (10) tick();

    // Simultaneous requests after reset: requester 0 first, then guard gap
    $display("phase: tie and guard gap");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("t2_gnt0", 32'(gnt0), 1);
    chk("t2_gnt1", 32'(gnt1), 0);
    req0 = 1'b0;
    tick();
    chk("t2_fall_gnt0", 32'(gnt0), 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t2_guard_gnt1", 32'(gnt1), 0);
      check_idle_bus("t2_guard");
    end
    tick();
    chk("t2_gnt1", 32'(gnt1), 1);
    chk("t2_owner", 32'(owner), 32'h2);
    chk("t2_io_o", 32'(io_o), 32'hC);
    chk("t2_io_t", 32'(io_t), 32'h3);
    chk("t2_ss_t", 32'(ss_t), 1);
    chk("t2_io1_i", 32'(io1_i), 32'hA);
    chk("t2_io0_i", 32'(io0_i), 32'h0);
    req1 = 1'b0;
    tick();
    chk("t2_rel_gnt1", 32'(gnt1), 0);
    repeat (10) tick();

    // Fairness: both always requesting, each releasing 10 cycles after its grant
    $display("phase: fairness");
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant("t3_wait", who);
      chk("t3_order", 32'(who), 32'(i % 2));
      chk("t3_exclusive", 32'(gnt0 & gnt1), 0);
      repeat (10) tick();
      if (who == 0) req0 = 1'b0; else req1 = 1'b0;
      tick();
      req0 = 1'b1; req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (12) tick();

    // Watchdog revoke and lockout
    $display("phase: watchdog revoke");
    req0 = 1'b1;
    tick();
    chk("t4_gnt0", 32'(gnt0), 1);
    req1 = 1'b1;
    repeat (15) tick();
    chk("t4_hold_gnt0", 32'(gnt0), 1);
    chk("t4_hold_timeout", 32'(timeout), 0);
    tick();
    chk("t4_rev_gnt0", 32'(gnt0), 0);
    chk("t4_rev_timeout", 32'(timeout), 1);
    tick();
    chk("t4_pulse_end", 32'(timeout), 0);
    repeat (7) tick();
    chk("t4_pre_gnt1", 32'(gnt1), 0);
    tick();
    chk("t4_gnt1", 32'(gnt1), 1);
    repeat (20) tick();
    chk("t4_locked_hold_gnt1", 32'(gnt1), 1);
    chk("t4_locked_no_timeout", 32'(timeout), 0);
    req1 = 1'b0;
    tick();
    chk("t4_rel_gnt1", 32'(gnt1), 0);
    repeat (12) tick();
    chk("t4_locked_gnt0", 32'(gnt0), 0);
    req0 = 1'b0;
    tick();
    req0 = 1'b1;
    wait_grant("t4_regrant_wait", who);
    chk("t4_regrant", 32'(who), 0);
    req0 = 1'b0;
    repeat (12) tick();

    // Release on the watchdog expiry edge: no pulse, no lockout
    $display("phase: release on expiry");
    req0 = 1'b1;
    tick();
    chk("t5_gnt0", 32'(gnt0), 1);
    req1 = 1'b1;
    repeat (15) tick();
    chk("t5_hold_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    tick();
    chk("t5_rel_gnt0", 32'(gnt0), 0);
    chk("t5_timeout", 32'(timeout), 0);
    req0 = 1'b1; req1 = 1'b0;
    tick();
    chk("t5_timeout_next", 32'(timeout), 0);
    repeat (7) tick();
    chk("t5_pre_gnt0", 32'(gnt0), 0);
    tick();
    chk("t5_no_lockout_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    repeat (12) tick();

    // Reset during requester 1 ownership
    $display("phase: reset mid-ownership");
    req1 = 1'b1;
    tick();
    chk("t6_gnt1", 32'(gnt1), 1);
    rst = 1'b1;
    tick();
    chk("t6_rst_gnt1", 32'(gnt1), 0);
    chk("t6_rst_owner", 32'(owner), 0);
    chk("t6_rst_io1_i", 32'(io1_i), 0);
    check_idle_bus("t6_rst");
    rst = 1'b0;
    req0 = 1'b1;
    tick();
    chk("t6_tie_gnt0", 32'(gnt0), 1);
    chk("t6_tie_gnt1", 32'(gnt1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qspi_flash_arbiter.md
Name: qspi_flash_arbiter

Overview:
- Two-requester arbiter for the shared configuration QSPI flash pins (ss, io[3:0]).
- Requester 0 is the host-side AXI Quad SPI; requester 1 is the on-card flash loader/updater.
- Grants exclusive ownership and muxes the owner's ss/io drive and tristate controls onto the pad-side IOBUF controls.
- Enforces a deselect guard gap between owners and revokes a starving hold via a watchdog.

Parameters:
- GUARD_CYCLES, 8: cycles ss is forced high with io tristated between owners; legal range 1..255.
- TIMEOUT_CYCLES, 65536: max ownership cycles while the other requester waits; 0 disables the watchdog.
- CNT_W, 17: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 ownership request; held high for the whole transaction
- gnt0  out  1  requester 0 owns the bus
- ss0_o  in  1  requester 0 chip-select drive
- ss0_t  in  1  requester 0 chip-select tristate
- io0_o  in  4  requester 0 data drive
- io0_t  in  4  requester 0 data tristate, per bit
- io0_i  out  4  pad data returned to requester 0
- req1, gnt1, ss1_o, ss1_t, io1_o, io1_t, io1_i: same as the requester 0 set, for requester 1
- ss_o  out  1  muxed chip-select drive to the pad buffer
- ss_t  out  1  muxed chip-select tristate
- io_o  out  4  muxed data drive
- io_t  out  4  muxed data tristate
- io_i  in  4  data from the pad buffers
- owner  out  2  status: 00 none, 01 req0, 10 req1
- timeout  out  1  one-cycle pulse when a grant is revoked

Behaviour:
- Reset values: gnt0=gnt1=0, owner=00, timeout=0, FSM=IDLE, last_owner=1 (so requester 0 wins the first tie), lockout0=lockout1=0, counters=0.
- Idle bus value, driven whenever owner=00: ss_o=1, ss_t=0, io_o=4'h0, io_t=4'hF, io0_i=io1_i=4'h0.
- Owned bus value: outputs are the owner's inputs, combinationally muxed on registered owner.
  - Owner receives io_i.
  - Non-owner's io*_i reads 4'h0.
- FSM states:
  - IDLE: evaluates eligible requests. Requester n is eligible when reqn=1 and lockoutn=0.
    - One eligible: grant it.
    - Both eligible: grant the one != last_owner.
    - Grant takes effect at the next edge: state=OWN, gntn=1, owner updated, last_owner=n, watchdog cleared.
    - Latency from req rising in IDLE to gnt = 1 cycle.
  - OWN: gnt held.
    - Owner's req low sampled at an edge: at that edge gnt=0, owner=00, state=GUARD, guard counter=GUARD_CYCLES-1.
    - Watchdog increments each cycle only while the other requester is eligible; holds otherwise.
    - Watchdog reaching TIMEOUT_CYCLES-1 with the other requester still eligible revokes the grant at the next edge: gnt=0, owner=00, timeout=1 for one cycle, lockout set for the revoked requester, state=GUARD.
  - GUARD: idle bus value driven; counter decrements to 0, then state=IDLE. Minimum gap from gnt fall to any gnt rise = GUARD_CYCLES+1 cycles.
- Lockout: lockoutn clears on the first cycle reqn is sampled low. A revoked requester must drop req before it is eligible again.
- Simultaneous events:
  - Owner drops req on the same edge the watchdog expires: treat as normal release; no timeout pulse, no lockout.
  - Req pulses shorter than one cycle while in GUARD are ignored; only the level seen in IDLE matters.
- Reset mid-transaction: next edge forces all outputs to reset values. The pad returns to the idle bus value in the same cycle owner clears.
- gnt0 and gnt1 are never high simultaneously; ss_t=0 and ss_o=1 whenever owner=00.

Test Plan:
- Reset then req0=1 at cycle 5 → gnt0=1 and owner=01 at cycle 6; ss_o/io_o follow ss0_o/io0_o. Drive io_i=4'hA → io0_i=4'hA, io1_i=4'h0.
- req0 and req1 rise together after reset → gnt0 first. req0 drops → gnt0 low next edge, ss_o=1 and io_t=4'hF for 8 cycles, gnt1=1 exactly 9 cycles after gnt0 fell.
- Back-to-back fairness: req0 and req1 held permanently, each dropping req 10 cycles after its grant → grants alternate 0,1,0,1.
- TIMEOUT_CYCLES=16, req0 owns and holds, req1 asserted → after 16 waiting cycles gnt0 drops and timeout pulses once. gnt1 rises GUARD_CYCLES+1 cycles later; req0 stays ineligible until it goes low.
- Release and watchdog expiry on the same edge → timeout stays 0, lockout0 stays 0.
- rst asserted mid-ownership by requester 1 → next edge gnt1=0, owner=00, ss_o=1, io_t=4'hF. After reset, simultaneous requests grant requester 0.
